// File: rtl/pcie_phys_pkg.sv
// rtl/pcie_phys_pkg.sv - shared PCIe PHY constants, running-disparity type and K-code check
package pcie_phys_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] FTS = 8'h3C;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] EIE = 8'hFC;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] PAD = 8'hF7;

  typedef enum logic {
    RD_NEG = 1'b0,
    RD_POS = 1'b1
  } rd_t;

  // Every K28.y is legal, plus the four K.x.7 codes used for framing.
  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == PAD) || (b == STP) || (b == END) || (b == EDB);
  endfunction

endpackage

// File: rtl/pcie_8b10b_lut.sv
// rtl/pcie_8b10b_lut.sv - combinational 8b/10b code lookup with running-disparity update
module pcie_8b10b_lut
  import pcie_phys_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  rd_t        rd_i,
  output logic [9:0] symbol_o,
  output rd_t        rd_o
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] m6;
  logic [5:0] c6;
  logic [3:0] p4;
  logic [3:0] c4;
  logic       bal6;
  logic       bal4;
  logic       rd6;
  logic       alt;
  logic       flip4;
  logic [9:0] code;

  assign x = data_i[4:0];
  assign y = data_i[7:5];

  always_comb begin
    // 6b codes as abcdei for the RD- column
    m6 = 6'b000000;
    case (x)
      5'd0:  m6 = 6'b100111;  5'd1:  m6 = 6'b011101;
      5'd2:  m6 = 6'b101101;  5'd3:  m6 = 6'b110001;
      5'd4:  m6 = 6'b110101;  5'd5:  m6 = 6'b101001;
      5'd6:  m6 = 6'b011001;  5'd7:  m6 = 6'b111000;
      5'd8:  m6 = 6'b111001;  5'd9:  m6 = 6'b100101;
      5'd10: m6 = 6'b010101;  5'd11: m6 = 6'b110100;
      5'd12: m6 = 6'b001101;  5'd13: m6 = 6'b101100;
      5'd14: m6 = 6'b011100;  5'd15: m6 = 6'b010111;
      5'd16: m6 = 6'b011011;  5'd17: m6 = 6'b100011;
      5'd18: m6 = 6'b010011;  5'd19: m6 = 6'b110010;
      5'd20: m6 = 6'b001011;  5'd21: m6 = 6'b101010;
      5'd22: m6 = 6'b011010;  5'd23: m6 = 6'b111010;
      5'd24: m6 = 6'b110011;  5'd25: m6 = 6'b100110;
      5'd26: m6 = 6'b010110;  5'd27: m6 = 6'b110110;
      5'd28: m6 = 6'b001110;  5'd29: m6 = 6'b101110;
      5'd30: m6 = 6'b011110;  5'd31: m6 = 6'b101011;
      default: m6 = 6'b000000;
    endcase
    if (k_i && x == 5'd28) m6 = 6'b001111;
    bal6 = ($countones(m6) == 3);
    // D.7 is balanced yet still has two forms
    c6  = (rd_i == RD_POS && (!bal6 || x == 5'd7)) ? ~m6 : m6;
    rd6 = rd_i ^ !bal6;

    // 4b codes as fghj for the RD+ column (disparity after the 6b block)
    p4 = 4'b0000;
    case (y)
      3'd0: p4 = 4'b0100;  3'd1: p4 = 4'b1001;
      3'd2: p4 = 4'b0101;  3'd3: p4 = 4'b0011;
      3'd4: p4 = 4'b0010;  3'd5: p4 = 4'b1010;
      3'd6: p4 = 4'b0110;  3'd7: p4 = 4'b0001;
      default: p4 = 4'b0000;
    endcase
    alt = k_i || (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                      : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    if (y == 3'd7 && alt) p4 = 4'b1000;
    // K codes invert every 4b column; data only the ones with two forms
    flip4 = k_i || y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7;
    c4    = (!rd6 && flip4) ? ~p4 : p4;
    bal4  = ($countones(c4) == 2);

    code     = {c6, c4};
    symbol_o = '0;
    for (int i = 0; i < 10; i++) symbol_o[i] = code[9-i];
    rd_o = rd_t'(rd6 ^ !bal4);
  end

endmodule

// File: rtl/pcie_8b10b_encoder.sv
// rtl/pcie_8b10b_encoder.sv - per-lane 8b/10b encoder with running disparity and registered valid/ready stage
module pcie_8b10b_encoder
  import pcie_phys_pkg::*;
#(
  parameter bit K_CHECK = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       disp_reset_i,
  output logic [9:0] symbol_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       invalid_k_o,
  output logic       rd_o
);

  rd_t        rd_q;
  rd_t        rd_start;
  rd_t        lut_rd;
  logic [9:0] lut_sym;
  logic [7:0] lut_data;
  logic       bad_k;
  logic       accept;

  assign ready_o  = !valid_o || ready_i;
  assign accept   = valid_i && ready_o;
  assign rd_start = disp_reset_i ? RD_NEG : rd_q;
  assign bad_k    = K_CHECK && k_i && !is_legal_k(data_i);
  // An illegal K byte is substituted with COM before lookup
  assign lut_data = bad_k ? COM : data_i;

  pcie_8b10b_lut u_lut (
    .data_i   (lut_data),
    .k_i      (k_i),
    .rd_i     (rd_start),
    .symbol_o (lut_sym),
    .rd_o     (lut_rd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q        <= RD_NEG;
      valid_o     <= 1'b0;
      symbol_o    <= '0;
      invalid_k_o <= 1'b0;
      rd_o        <= 1'b0;
    end else begin
      if (accept) rd_q <= lut_rd;
      else if (disp_reset_i) rd_q <= RD_NEG;

      if (accept) begin
        valid_o     <= 1'b1;
        symbol_o    <= lut_sym;
        invalid_k_o <= bad_k;
        rd_o        <= lut_rd;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_8b10b_encoder.sv
// tb/tb_pcie_8b10b_encoder.sv - scoreboard testbench for pcie_8b10b_encoder
module tb_pcie_8b10b_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = '0;
  logic       k_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       disp_reset_i = 1'b0;
  logic [9:0] symbol_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       invalid_k_o;
  logic       rd_o;

  always #5 clk = ~clk;

  pcie_8b10b_encoder #(.K_CHECK(1'b1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_i       (data_i),
    .k_i          (k_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .disp_reset_i (disp_reset_i),
    .symbol_o     (symbol_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .invalid_k_o  (invalid_k_o),
    .rd_o         (rd_o)
  );

  typedef struct {
    logic [9:0] sym;
    logic       rd;
    logic       inv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic model_rd = 1'b0;

  logic [5:0] m6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                          6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                          6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] p6 [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                          6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                          6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                          6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] dm4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] dp4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] km4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] kp4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] klist [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  function automatic int ones(input logic [5:0] v);
    int n = 0;
    for (int i = 0; i < 6; i++) n += int'(v[i]);
    return n;
  endfunction

  // Returns {rd_after, symbol} for a legal byte encoded from rd
  function automatic logic [10:0] model_enc(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x = b[4:0];
    logic [2:0] y = b[7:5];
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic       rdo;
    if (k && x == 5'd28) c6 = rd ? 6'b110000 : 6'b001111;
    else                 c6 = rd ? p6[x] : m6[x];
    rd6 = (ones(c6) == 3) ? rd : !rd;
    if (k)
      c4 = rd6 ? kp4[y] : km4[y];
    else if (y == 3'd7 && !rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20))
      c4 = 4'b0111;
    else if (y == 3'd7 && rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))
      c4 = 4'b1000;
    else
      c4 = rd6 ? dp4[y] : dm4[y];
    rdo = (ones({2'b00, c4}) == 2) ? rd6 : !rd6;
    return {rdo, c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a byte just after a posedge and returns just after the posedge that accepts it
  task automatic drive(input logic [7:0] d, input logic k, input logic dr, input logic use_model,
                       input logic [9:0] csym, input logic crd, input logic cinv);
    exp_t        e;
    logic [10:0] m;
    bit          ok = 1'b0;
    data_i = d; k_i = k; valid_i = 1'b1; disp_reset_i = dr;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; break; end
    end
    chk("accept_in_time", 32'(ok), 32'd1);
    if (dr) model_rd = 1'b0;
    if (use_model) begin
      m = model_enc(d, k, model_rd);
      e.sym = m[9:0]; e.rd = m[10]; e.inv = 1'b0;
    end else begin
      e.sym = csym; e.rd = crd; e.inv = cinv;
    end
    model_rd = e.rd;
    sb.push_back(e);
    @(posedge clk); #1;
    disp_reset_i = 1'b0;
  endtask

  task automatic idle();
    valid_i = 1'b0; disp_reset_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin @(posedge clk); #1; end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      chk("scoreboard_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("symbol", symbol_o, e.sym);
        chk("rd", rd_o, e.rd);
        chk("invalid_k", invalid_k_o, e.inv);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_symbol", symbol_o, 0);
    chk("rst_invalid_k", invalid_k_o, 0);
    chk("rst_rd", rd_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", ready_o, 1);

    drive(8'h00, 1'b0, 1'b0, 1'b0, 10'h0B9, 1'b0, 1'b0);
    idle();
    drain();

    drive(8'hBC, 1'b1, 1'b0, 1'b0, 10'h17C, 1'b1, 1'b0);
    chk("b2b_valid_1", valid_o, 1);
    drive(8'hBC, 1'b1, 1'b0, 1'b0, 10'h283, 1'b0, 1'b0);
    chk("b2b_valid_2", valid_o, 1);
    idle();
    chk("b2b_valid_after", valid_o, 0);

    drive(8'hF1, 1'b0, 1'b1, 1'b0, 10'h3B1, 1'b1, 1'b0);
    idle();
    drive(8'hBC, 1'b1, 1'b1, 1'b0, 10'h17C, 1'b1, 1'b0);
    drive(8'hEB, 1'b0, 1'b0, 1'b0, 10'h04B, 1'b0, 1'b0);
    idle();

    drive(8'h00, 1'b1, 1'b1, 1'b0, 10'h17C, 1'b1, 1'b1);
    drive(8'hB5, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b0);
    idle();
    drain();

    ready_i = 1'b0;
    drive(8'hB5, 1'b0, 1'b1, 1'b0, 10'h155, 1'b0, 1'b0);
    data_i = 8'h00; k_i = 1'b0; valid_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_symbol", symbol_o, 10'h155);
      chk("stall_ready", ready_o, 0);
      chk("stall_valid", valid_o, 1);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 10'h0B9, 1'b0, 1'b0);
    idle();
    drain();

    drive(8'hBC, 1'b1, 1'b1, 1'b0, 10'h17C, 1'b1, 1'b0);
    idle();
    drive(8'hBC, 1'b1, 1'b1, 1'b0, 10'h17C, 1'b1, 1'b0);
    idle();
    disp_reset_i = 1'b1;
    @(posedge clk); #1;
    disp_reset_i = 1'b0;
    drive(8'hBC, 1'b1, 1'b0, 1'b0, 10'h17C, 1'b1, 1'b0);
    idle();
    drain();

    ready_i = 1'b0;
    drive(8'hB5, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b0);
    valid_i = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_symbol", symbol_o, 0);
    chk("midrst_rd", rd_o, 0);
    chk("midrst_pending", sb.size(), 1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_i = 1'b1;
    model_rd = 1'b0;
    @(posedge clk); #1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 10'h0B9, 1'b0, 1'b0);
    idle();
    drain();

    for (int i = 0; i < 268; i++) begin
      logic [7:0] code;
      logic       kk;
      kk   = (i >= 256);
      code = kk ? klist[i-256] : 8'(i);
      drive(code, kk, 1'b1, 1'b1, '0, 1'b0, 1'b0);
      drive(8'hBC, 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0);
      drive(code, kk, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
